// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the 4-bit CPU control path: opcodes, ALU functions,
// controller states and datapath mux select values.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_JMP  = 4'h8,
        OP_BZ   = 4'h9,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_operation_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        HALT
    } ctrl_state_t;

    localparam logic [1:0] SEL1_PC   = 2'd0;
    localparam logic [1:0] SEL1_RD1  = 2'd1;
    localparam logic [1:0] SEL1_ZERO = 2'd2;

    localparam logic [1:0] SEL2_RD2  = 2'd0;
    localparam logic [1:0] SEL2_ONE  = 2'd1;
    localparam logic [1:0] SEL2_IMM  = 2'd2;

    localparam logic [1:0] RES_MEM   = 2'd0;
    localparam logic [1:0] RES_ALU   = 2'd1;
    localparam logic [1:0] RES_IMM   = 2'd2;

    // Unassigned codes (0xA-0xE) retire through the same two-cycle path as NOP.
    function automatic logic is_nop(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
            OP_LD, OP_ST, OP_JMP, OP_BZ, OP_HALT: is_nop = 1'b0;
            default:                              is_nop = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational opcode to ALU function mapping for register-register and
// immediate arithmetic instructions.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  opcode_t        opcode,
    output alu_operation_t alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 4-bit CPU. Optional CTRL_RETIRE_COUNT_EN
// adds a saturating 8-bit count of retired instructions on port `retired`.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  opcode_t        opcode,
    input  logic           zero,
    output logic           ir_write,
    output logic           pc_write,
    output logic           reg_write,
    output logic           mem_write,
    output logic           zero_write,
    output logic [1:0]     alu_sel1,
    output logic [1:0]     alu_sel2,
    output alu_operation_t alu_op,
    output logic [1:0]     result_sel,
    output logic           halted
`ifdef CTRL_RETIRE_COUNT_EN
    ,
    output logic [7:0]     retired
`endif
);

    ctrl_state_t    state;
    alu_operation_t dec_op;

    alu_decoder u_alu_decoder (
        .opcode (opcode),
        .alu_op (dec_op)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (run) state <= FETCH;
                FETCH:   state <= DECODE;
                DECODE: begin
                    if (opcode == OP_HALT)  state <= HALT;
                    else if (is_nop(opcode)) state <= run ? FETCH : IDLE;
                    else                     state <= EXEC;
                end
                EXEC: begin
                    if (opcode == OP_LD) state <= MEM;
                    else                 state <= run ? FETCH : IDLE;
                end
                MEM:     state <= run ? FETCH : IDLE;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are masked during reset so an abandoned EXEC/MEM never strobes.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        zero_write = 1'b0;
        alu_sel1   = SEL1_PC;
        alu_sel2   = SEL2_RD2;
        alu_op     = ALU_ADD;
        result_sel = RES_MEM;
        halted     = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_sel1   = SEL1_PC;
                    alu_sel2   = SEL2_ONE;
                    result_sel = RES_ALU;
                end
                EXEC: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            alu_sel1   = SEL1_RD1;
                            alu_sel2   = (opcode == OP_ADDI) ? SEL2_IMM : SEL2_RD2;
                            alu_op     = dec_op;
                            result_sel = RES_ALU;
                            reg_write  = 1'b1;
                            zero_write = 1'b1;
                        end
                        OP_ST:  mem_write = 1'b1;
                        OP_JMP: begin
                            result_sel = RES_IMM;
                            pc_write   = 1'b1;
                        end
                        OP_BZ: begin
                            result_sel = RES_IMM;
                            pc_write   = zero;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    result_sel = RES_MEM;
                    reg_write  = 1'b1;
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_RETIRE_COUNT_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        case (state)
            DECODE:  retire = is_nop(opcode);
            EXEC:    retire = (opcode != OP_LD);
            MEM:     retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            retired <= '0;
        else if (retire && retired != 8'hFF)
            retired <= retired + 8'd1;
    end
`endif

endmodule
